mem_scan_controller: RTL and testbench

- Sequences timed reads of the 1024 x 16 display memory and holds the result in MDR for the seven-segment drivers.
- Replaces a free-running read loop with a controllable scanner:
  - run/pause and single-step control
  - up/down scan direction
  - programmable address window [LO_ADDR, HI_ADDR] with wrap-around
  - parameterised read latency for synchronous RAM
- Sits between the board controls (KEY/SW) and the memory read port; MDR feeds the hex display decoders.

---
 rtl/mem_scan_controller.sv | 140 ++++++++++++++
 tb/tb_mem_scan_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_scan_controller.sv
// Timed scanner for the 1024 x 16 display memory: a prescaler tick or STEP starts one read,
// and the returned word is held in MDR while MAR walks the [LO_ADDR, HI_ADDR] window.
module mem_scan_controller #(
    parameter int TICK_DIV = 25000000,
    parameter int MEM_LAT  = 1,
    parameter int CNT_W    = 32
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        RUN,
    input  logic        STEP,
    input  logic        DIR,
    input  logic [9:0]  LO_ADDR,
    input  logic [9:0]  HI_ADDR,
    output logic [9:0]  MEM_ADDR,
    output logic        MEM_RD,
    input  logic [15:0] MEM_RDATA,
    output logic [9:0]  MAR,
    output logic [15:0] MDR,
    output logic        MDR_VALID,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       mar_q, mar_d;
    logic [9:0]       addr_q, addr_d;
    logic [15:0]      mdr_q, mdr_d;
    logic             rd_q, rd_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic             trig;
    logic [9:0]       mar_next;

    // An inverted window (lo > hi) degrades to a plain modular 10-bit walk.
    function automatic logic [9:0] next_addr(input logic [9:0] cur,
                                             input logic [9:0] lo,
                                             input logic [9:0] hi,
                                             input logic       dir);
        logic [9:0] res;
        if (lo <= hi) begin
            if (!dir) begin
                res = (cur >= hi) ? lo : cur + 10'd1;
            end else begin
                res = (cur <= lo) ? hi : cur - 10'd1;
            end
        end else begin
            res = dir ? cur - 10'd1 : cur + 10'd1;
        end
        return res;
    endfunction

    always_comb begin
        tick  = RUN && (cnt_q == TICK_LAST);
        cnt_d = (!RUN || tick) ? '0 : cnt_q + CNT_W'(1);
        trig  = tick | STEP;
    end

    always_comb begin
        mar_next = next_addr(mar_q, LO_ADDR, HI_ADDR, DIR);
    end

    // Outputs are computed for the state being entered so they register in step with it.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = READ;
                    rd_d    = 1'b1;
                    addr_d  = mar_q;
                    busy_d  = 1'b1;
                end
            end
            READ: begin
                state_d = (MEM_LAT == 2) ? WAIT : LATCH;
                busy_d  = 1'b1;
            end
            WAIT: begin
                state_d = LATCH;
                busy_d  = 1'b1;
            end
            LATCH: begin
                state_d = IDLE;
                mdr_d   = MEM_RDATA;
                mar_d   = mar_next;
                valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign MEM_ADDR  = addr_q;
    assign MEM_RD    = rd_q;
    assign MAR       = mar_q;
    assign MDR       = mdr_q;
    assign MDR_VALID = valid_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_mem_scan_controller.sv
// Bench for mem_scan_controller: two instances (read latency 1 and 2) share stimulus and are
// compared every cycle against a transaction-level model, plus table vectors and corner sequences.
module tb_mem_scan_controller;

    localparam int TD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, run, step, dir;
    logic [9:0]  lo, hi;
    logic [9:0]  a_addr, a_mar, b_addr, b_mar;
    logic        a_rd, a_valid, a_busy, b_rd, b_valid, b_busy;
    logic [15:0] a_rdata, b_rdata, b_pipe, a_mdr, b_mdr;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, index 0 = latency 1, index 1 = latency 2.
    int m_cnt[2], m_left[2], m_mar[2], m_mdr[2], m_addr[2];
    int m_valid[2], m_busy[2], m_rd[2];

    typedef struct {
        int lo;
        int hi;
        int dir;
        int exp_mdr;
        int exp_mar;
    } vec_t;
    vec_t tbl[19];

    mem_scan_controller #(.TICK_DIV(TD), .MEM_LAT(1), .CNT_W(32)) dut_a (
        .CLOCK_50(clk), .RESET_N(rst_n), .RUN(run), .STEP(step), .DIR(dir),
        .LO_ADDR(lo), .HI_ADDR(hi), .MEM_ADDR(a_addr), .MEM_RD(a_rd),
        .MEM_RDATA(a_rdata), .MAR(a_mar), .MDR(a_mdr), .MDR_VALID(a_valid), .BUSY(a_busy));

    mem_scan_controller #(.TICK_DIV(TD), .MEM_LAT(2), .CNT_W(32)) dut_b (
        .CLOCK_50(clk), .RESET_N(rst_n), .RUN(run), .STEP(step), .DIR(dir),
        .LO_ADDR(lo), .HI_ADDR(hi), .MEM_ADDR(b_addr), .MEM_RD(b_rd),
        .MEM_RDATA(b_rdata), .MAR(b_mar), .MDR(b_mdr), .MDR_VALID(b_valid), .BUSY(b_busy));

    function automatic logic [15:0] memval(input logic [9:0] a);
        return 16'hA000 + {6'd0, a};
    endfunction

    // Memories drive garbage except on the one cycle their data is valid.
    always @(posedge clk) begin
        a_rdata <= a_rd ? memval(a_addr) : 16'hDEAD;
        b_pipe  <= b_rd ? memval(b_addr) : 16'hDEAD;
        b_rdata <= b_pipe;
    end

    function automatic int next_model(input int mar, input int wlo, input int whi, input int d);
        if (wlo <= whi) begin
            if (d == 0) return (mar >= whi) ? wlo : mar + 1;
            else        return (mar <= wlo) ? whi : mar - 1;
        end
        return (d != 0) ? (mar + 1023) % 1024 : (mar + 1) % 1024;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_left[i] = 0; m_mar[i] = 0; m_mdr[i] = 0; m_addr[i] = 0;
            m_valid[i] = 0; m_busy[i] = 0; m_rd[i] = 0;
        end
    endtask

    // One cycle of the model: a read holds the block for latency+1 cycles after its trigger.
    task automatic model_step();
        int tk;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            tk = (run && m_cnt[i] == TD - 1) ? 1 : 0;
            m_cnt[i] = (run && tk == 0) ? m_cnt[i] + 1 : 0;
            m_valid[i] = 0;
            m_rd[i] = 0;
            if (m_left[i] > 0) begin
                if (m_left[i] == 1) begin
                    m_mdr[i] = 'hA000 + m_mar[i];
                    m_mar[i] = next_model(m_mar[i], int'(lo), int'(hi), int'(dir));
                    m_valid[i] = 1;
                end
                m_left[i]--;
            end else if (tk != 0 || step) begin
                m_left[i] = i + 2;
                m_rd[i] = 1;
                m_addr[i] = m_mar[i];
            end
            m_busy[i] = (m_left[i] > 0) ? 1 : 0;
        end
    endtask

    task automatic check_dut(input int i, input int valid, input int busy, input int rd,
                             input int addr, input int mar, input int mdr);
        check($sformatf("dut%0d MDR_VALID", i), valid, m_valid[i]);
        check($sformatf("dut%0d BUSY", i), busy, m_busy[i]);
        check($sformatf("dut%0d MEM_RD", i), rd, m_rd[i]);
        check($sformatf("dut%0d MEM_ADDR", i), addr, m_addr[i]);
        check($sformatf("dut%0d MAR", i), mar, m_mar[i]);
        check($sformatf("dut%0d MDR", i), mdr, m_mdr[i]);
    endtask

    // Advance one clock with the inputs currently driven, then compare both instances.
    task automatic applyStimulus();
        model_step();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkOutput();
        check_dut(0, int'(a_valid), int'(a_busy), int'(a_rd), int'(a_addr), int'(a_mar), int'(a_mdr));
        check_dut(1, int'(b_valid), int'(b_busy), int'(b_rd), int'(b_addr), int'(b_mar), int'(b_mdr));
    endtask

    initial begin
        int vc, found, rdcnt, vfirst, mar0;

        tbl[0]  = '{0, 1023, 0, 'hA000, 1};
        tbl[1]  = '{5, 7, 0, 'hA001, 2};
        tbl[2]  = '{5, 7, 0, 'hA002, 3};
        tbl[3]  = '{5, 7, 0, 'hA003, 4};
        tbl[4]  = '{5, 7, 0, 'hA004, 5};
        tbl[5]  = '{5, 7, 0, 'hA005, 6};
        tbl[6]  = '{5, 7, 0, 'hA006, 7};
        tbl[7]  = '{5, 7, 0, 'hA007, 5};
        tbl[8]  = '{5, 7, 0, 'hA005, 6};
        tbl[9]  = '{5, 7, 1, 'hA006, 5};
        tbl[10] = '{5, 7, 1, 'hA005, 7};
        tbl[11] = '{5, 7, 1, 'hA007, 6};
        tbl[12] = '{0, 0, 0, 'hA006, 0};
        tbl[13] = '{10, 3, 1, 'hA000, 1023};
        tbl[14] = '{10, 3, 1, 'hA3FF, 1022};
        tbl[15] = '{10, 3, 0, 'hA3FE, 1023};
        tbl[16] = '{10, 3, 0, 'hA3FF, 0};
        tbl[17] = '{1023, 1023, 1, 'hA000, 1023};
        tbl[18] = '{5, 7, 0, 'hA3FF, 5};

        rst_n = 1'b0; run = 1'b0; step = 1'b0; dir = 1'b0; lo = 10'd0; hi = 10'd1023;
        model_reset();
        #2;
        check("reset MAR", int'(a_mar), 0);
        check("reset MDR", int'(a_mdr), 0);
        check("reset MDR_VALID", int'(a_valid), 0);
        check("reset BUSY", int'(a_busy), 0);
        check("reset MEM_RD", int'(a_rd), 0);
        check("reset MEM_ADDR", int'(a_addr), 0);
        applyStimulus();
        applyStimulus();

        // Free-running scan straight out of reset.
        rst_n = 1'b1; run = 1'b1;
        vc = 0;
        for (int n = 1; n <= 34; n++) begin
            applyStimulus();
            if (a_valid) begin
                check("run valid cycle", n, 10 + 8 * vc);
                check("run MDR", int'(a_mdr), 'hA000 + vc);
                check("run MAR", int'(a_mar), vc + 1);
                vc++;
            end
        end
        check("run valid count", vc, 4);

        run = 1'b0;
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();

        // Single-step table: each vector is one STEP under the given window and direction.
        for (int v = 0; v < 19; v++) begin
            lo = 10'(tbl[v].lo); hi = 10'(tbl[v].hi); dir = 1'(tbl[v].dir);
            step = 1'b1;
            applyStimulus();
            step = 1'b0;
            found = 0;
            for (int k = 0; k < 8 && found == 0; k++) begin
                applyStimulus();
                if (a_valid) found = 1;
            end
            check($sformatf("tbl%0d valid seen", v), found, 1);
            check($sformatf("tbl%0d MDR", v), int'(a_mdr), tbl[v].exp_mdr);
            check($sformatf("tbl%0d MAR", v), int'(a_mar), tbl[v].exp_mar);
            applyStimulus();
        end

        // Latency-2 step with a second STEP landing while busy.
        lo = 10'd0; hi = 10'd1023; dir = 1'b0;
        repeat (3) applyStimulus();
        step = 1'b1;
        applyStimulus();
        check("step MEM_RD c+1", int'(b_rd), 1);
        rdcnt = int'(b_rd);
        step = 1'b0;
        applyStimulus();
        check("step BUSY c+2", int'(b_busy), 1);
        rdcnt += int'(b_rd);
        step = 1'b1;
        applyStimulus();
        rdcnt += int'(b_rd);
        step = 1'b0;
        applyStimulus();
        check("step MDR_VALID c+4", int'(b_valid), 1);
        rdcnt += int'(b_rd);
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            rdcnt += int'(b_rd);
        end
        check("step single read", rdcnt, 1);

        // Reset asserted while the latency-2 instance sits in WAIT.
        step = 1'b1;
        applyStimulus();
        step = 1'b0;
        applyStimulus();
        check("wait BUSY before reset", int'(b_busy), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("abort MAR", int'(b_mar), 0);
        check("abort MDR", int'(b_mdr), 0);
        check("abort MDR_VALID", int'(b_valid), 0);
        check("abort BUSY", int'(b_busy), 0);
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1; run = 1'b1;
        vfirst = 0;
        for (int n = 1; n <= 12; n++) begin
            applyStimulus();
            if (a_valid && vfirst == 0) vfirst = n;
        end
        check("prescaler restart first valid", vfirst, 10);

        // STEP in the same cycle as a tick.
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            applyStimulus();
            if (m_cnt[0] == TD - 1 && m_left[0] == 0) found = 1;
        end
        check("tick search", found, 1);
        mar0 = m_mar[0];
        step = 1'b1;
        applyStimulus();
        step = 1'b0;
        rdcnt = int'(a_rd);
        for (int k = 0; k < 6; k++) begin
            applyStimulus();
            rdcnt += int'(a_rd);
        end
        check("coincident reads", rdcnt, 1);
        check("coincident MAR", int'(a_mar), (mar0 + 1) % 1024);

        // Randomised run against the model.
        for (int n = 0; n < 1500; n++) begin
            if (n % 60 == 0) begin
                case ($urandom_range(0, 2))
                    0: begin lo = 10'd0; hi = 10'd1023; end
                    1: begin lo = 10'($urandom_range(0, 20)); hi = lo + 10'($urandom_range(0, 5)); end
                    default: begin lo = 10'($urandom_range(0, 1023)); hi = 10'($urandom_range(0, 1023)); end
                endcase
            end
            step = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 9) == 0) dir = 1'($urandom_range(0, 1));
            applyStimulus();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
